// File: rtl/alu_datapath.sv
// Accumulator datapath: enALU latches op, enA latches din, enC writes ALU(C, A, op) into C and the flags.
// Every output is registered; there is no backpressure, and a strobe out of order or overlapping another sets sticky err.
module alu_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             CLKb,
   input  logic             RST,
   input  logic             enA,
   input  logic             enALU,
   input  logic             enC,
   input  logic [WIDTH-1:0] din,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] C,
   output logic             zf,
   output logic             nf,
   output logic             cf,
   output logic             vf,
   output logic             done,
   output logic             err,
   output logic [1:0]       phase
);

   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] WAIT_OP = 2'b00;
   localparam logic [1:0] WAIT_A  = 2'b01;
   localparam logic [1:0] WAIT_C  = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   logic [WIDTH-1:0] a_q;
   logic [2:0]       opc_q;
   logic [WIDTH-1:0] res;
   logic             res_cf;
   logic             res_vf;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             any_en;
   logic             multi_en;
   logic             legal_en;

   always_comb begin
      sum    = {1'b0, C} + {1'b0, a_q};
      diff   = {1'b0, C} - {1'b0, a_q};
      res    = '0;
      res_cf = 1'b0;
      res_vf = 1'b0;
      case (opc_q)
         OP_ADD: begin
            res    = sum[MSB:0];
            res_cf = sum[WIDTH];
            res_vf = (C[MSB] == a_q[MSB]) && (sum[MSB] != C[MSB]);
         end
         OP_SUB: begin
            // The extra top bit of the subtraction is the unsigned borrow.
            res    = diff[MSB:0];
            res_cf = diff[WIDTH];
            res_vf = (C[MSB] != a_q[MSB]) && (diff[MSB] != C[MSB]);
         end
         OP_AND:  res = C & a_q;
         OP_OR:   res = C | a_q;
         OP_XOR:  res = C ^ a_q;
         OP_LOAD: res = a_q;
         OP_SHL: begin
            res    = {C[MSB-1:0], 1'b0};
            res_cf = C[MSB];
         end
         OP_SHR: begin
            res    = {1'b0, C[MSB:1]};
            res_cf = C[0];
         end
      endcase
   end

   assign any_en   = enA | enALU | enC;
   assign multi_en = (enA & enALU) | (enA & enC) | (enALU & enC);
   assign legal_en = ((phase == WAIT_OP) & enALU) |
                     ((phase == WAIT_A)  & enA)   |
                     ((phase == WAIT_C)  & enC);

   always_ff @(posedge CLKb) begin
      if (RST) begin
         C     <= '0;
         a_q   <= '0;
         opc_q <= '0;
         zf    <= 1'b0;
         nf    <= 1'b0;
         cf    <= 1'b0;
         vf    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         phase <= WAIT_OP;
      end else begin
         done <= 1'b0;
         if (phase == ILLEGAL) begin
            phase <= WAIT_OP;
         end else if (any_en) begin
            if (multi_en || !legal_en) begin
               err   <= 1'b1;
               phase <= WAIT_OP;
            end else begin
               case (phase)
                  WAIT_OP: begin
                     opc_q <= op;
                     phase <= WAIT_A;
                  end
                  WAIT_A: begin
                     a_q   <= din;
                     phase <= WAIT_C;
                  end
                  default: begin
                     C     <= res;
                     zf    <= (res == '0);
                     nf    <= res[MSB];
                     cf    <= res_cf;
                     vf    <= res_vf;
                     done  <= 1'b1;
                     phase <= WAIT_OP;
                  end
               endcase
            end
         end
      end
   end

endmodule
